// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: request ports m0/m1 and DM bus between masters, arbiter and memory
//   master : drives m*_req/we/sel/addr/wdata and dm_rdata; sees acks, read data and dm_* outputs
//   slave  : arbiter view, the reverse directions
interface dm_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              m0_req, m0_we, m0_ack, m0_err;
    logic [2:0]        m0_sel;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_ack, m1_err;
    logic [2:0]        m1_sel;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata, m1_rdata;
    logic              dm_we;
    logic [2:0]        dm_sel;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata, dm_rdata;
    modport master (
        output m0_req, m0_we, m0_sel, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_sel, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  dm_we, dm_sel, dm_addr, dm_wdata,
        output dm_rdata
    );
    modport slave (
        input  m0_req, m0_we, m0_sel, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_sel, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output dm_we, dm_sel, dm_addr, dm_wdata,
        input  dm_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port DM arbiter, one access per grant (IDLE -> ACCESS -> RESP)
//   clk   : system clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : m0_*/m1_* request ports (ack, err, registered rdata) and dm_* memory port
module dm_arbiter #(
    parameter int ADDR_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic         clk,
    input logic         RESET,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state;
    logic              gnt, ptr, r_we, win, w_we, mis;
    logic [2:0]        w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] a);
        return (sel[1:0] == 2'b01 && a[0]) || (sel[1] && a != 2'b00);
    endfunction
    // ptr holds the last winner; on a tie the other port wins unless port 0 has fixed priority
    always_comb begin
        win     = ~(bus.m0_req & (~bus.m1_req | FIXED_PRIO | ptr));
        w_we    = win ? bus.m1_we : bus.m0_we;
        w_sel   = win ? bus.m1_sel : bus.m0_sel;
        w_addr  = win ? bus.m1_addr : bus.m0_addr;
        w_wdata = win ? bus.m1_wdata : bus.m0_wdata;
        mis     = misaligned(bus.dm_sel, bus.dm_addr[1:0]);
    end
    // dm_sel/dm_addr/dm_wdata double as the request registers and hold between accesses
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            ptr          <= 1'b1;
            r_we         <= 1'b0;
            bus.dm_we    <= 1'b0;
            bus.dm_sel   <= '0;
            bus.dm_addr  <= '0;
            bus.dm_wdata <= '0;
            bus.m0_ack   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_ack   <= 1'b0;
            bus.m1_err   <= 1'b0;
            bus.m1_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (bus.m0_req | bus.m1_req) begin
                    gnt          <= win;
                    ptr          <= win;
                    r_we         <= w_we;
                    bus.dm_sel   <= w_sel;
                    bus.dm_addr  <= w_addr;
                    bus.dm_wdata <= w_wdata;
                    bus.dm_we    <= w_we & ~misaligned(w_sel, w_addr[1:0]);
                    state        <= ACCESS;
                end
                ACCESS: begin
                    bus.dm_we    <= 1'b0;
                    bus.m0_rdata <= (!r_we && !gnt) ? bus.dm_rdata : bus.m0_rdata;
                    bus.m1_rdata <= (!r_we && gnt) ? bus.dm_rdata : bus.m1_rdata;
                    bus.m0_ack   <= ~gnt;
                    bus.m0_err   <= ~gnt & mis;
                    bus.m1_ack   <= gnt;
                    bus.m1_err   <= gnt & mis;
                    state        <= RESP;
                end
                default: begin
                    bus.m0_ack <= 1'b0;
                    bus.m0_err <= 1'b0;
                    bus.m1_ack <= 1'b0;
                    bus.m1_err <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: vector table plus corner-case sequences with a scoreboard of expected acks
module tb_dm_arbiter;
    typedef struct {
        logic        port;
        logic        we;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic RESET = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(32)) bus ();
    dm_arbiter_if #(.ADDR_W(32)) bus1 ();
    dm_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b0)) dut (.clk(clk), .RESET(RESET), .bus(bus.slave));
    dm_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b1)) dut1 (.clk(clk), .RESET(RESET), .bus(bus1.slave));

    // byte-addressed little-endian DM model, combinational read with sign/zero extension
    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  ma, wb, rb;
    logic [15:0] rh;
    logic [31:0] rd;
    always_comb begin
        ma = bus.dm_addr[7:0];
        wb = {ma[7:2], 2'b00};
        rb = mem[ma];
        rh = {mem[ma + 8'd1], mem[ma]};
        rd = bus.dm_sel[1] ? {mem[wb + 8'd3], mem[wb + 8'd2], mem[wb + 8'd1], mem[wb]}
           : bus.dm_sel[0] ? (bus.dm_sel[2] ? {16'h0, rh} : {{16{rh[15]}}, rh})
           : (bus.dm_sel[2] ? {24'h0, rb} : {{24{rb[7]}}, rb});
    end
    assign bus.dm_rdata  = rd;
    assign bus1.dm_rdata = 32'h0;
    always @(posedge clk) begin
        if (bus.dm_we) begin
            if (bus.dm_sel[1]) begin
                mem[wb]        <= bus.dm_wdata[7:0];
                mem[wb + 8'd1] <= bus.dm_wdata[15:8];
                mem[wb + 8'd2] <= bus.dm_wdata[23:16];
                mem[wb + 8'd3] <= bus.dm_wdata[31:24];
            end else if (bus.dm_sel[0]) begin
                mem[ma]        <= bus.dm_wdata[7:0];
                mem[ma + 8'd1] <= bus.dm_wdata[15:8];
            end else
                mem[ma] <= bus.dm_wdata[7:0];
        end
    end

    int   n_chk = 0, n_fail = 0, cyc = 0, f_ack0 = 0, f_ack1 = 0;
    exp_t sbq[$];
    int   ack_cyc[$];
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic p, input logic [31:0] r, input logic e);
        exp_t x;
        x.port  = p;
        x.rdata = r;
        x.err   = e;
        sbq.push_back(x);
    endtask

    task automatic drive(input logic p, input logic req, input logic we, input logic [2:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_sel = sel; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_sel = sel; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // scoreboard: every ack pops the oldest expected completion
    initial forever begin
        @(posedge clk);
        #1;
        if (bus1.m0_ack) f_ack0++;
        if (bus1.m1_ack) f_ack1++;
        if (bus.m0_ack | bus.m1_ack) begin
            ack_cyc.push_back(cyc);
            chk("ack_onehot", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
            if (sbq.size() == 0)
                chk("unexpected_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("ack_port", 32'(bus.m1_ack), 32'(e.port));
                chk("rdata", e.port ? bus.m1_rdata : bus.m0_rdata, e.rdata);
                chk("err", 32'(e.port ? bus.m1_err : bus.m0_err), 32'(e.err));
            end
        end else
            chk("err_without_ack", 32'({bus.m1_err, bus.m0_err}), 32'd0);
    end

    task automatic access(input vec_t v);
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.sel, v.addr, v.wdata);
        push(v.port, v.rdata, v.err);
        @(posedge clk);
        #1;
        chk("dm_we_access", 32'(bus.dm_we), 32'(v.we & ~v.err));
        chk("dm_addr", bus.dm_addr, v.addr);
        chk("dm_sel", 32'(bus.dm_sel), 32'(v.sel));
        chk("ack_too_early", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
        @(posedge clk);
        #1;
        chk("ack_latency", 32'(v.port ? bus.m1_ack : bus.m0_ack), 32'd1);
        chk("dm_we_resp", 32'(bus.dm_we), 32'd0);
        @(negedge clk);
        drive(v.port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("ack_one_cycle", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b010, 32'h20, 32'h12345680, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h20, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h20, 32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h22, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'h12345680, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h22, 32'h0,        32'h00001234, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'b000, 32'h31, 32'h000000AA, 32'h00001234, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'b010, 32'h30, 32'h0,        32'h0000AA00, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h20, 32'h0,        32'h00005680, 1'b0};
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_sel = 3'b010; bus1.m0_addr = 32'h0; bus1.m0_wdata = 32'h0;
        bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_sel = 3'b010; bus1.m1_addr = 32'h4; bus1.m1_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
        chk("rst_dm_sel", 32'(bus.dm_sel), 32'd0);
        chk("rst_dm_addr", bus.dm_addr, 32'd0);
        chk("rst_dm_wdata", bus.dm_wdata, 32'd0);
        chk("rst_acks", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
        chk("rst_errs", 32'({bus.m1_err, bus.m0_err}), 32'd0);
        chk("rst_m0_rdata", bus.m0_rdata, 32'd0);
        chk("rst_m1_rdata", bus.m1_rdata, 32'd0);
        @(negedge clk);
        RESET = 1'b1;

        for (int i = 0; i < 12; i++) access(vecs[i]);
        chk("misaligned_mem_unchanged", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h12345680);

        // both ports saturated: m0,m1,m0,m1 one ack every 3 cycles
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        push(1'b0, 32'h0000AA00, 1'b0);
        push(1'b1, 32'h12345680, 1'b0);
        push(1'b0, 32'h0000AA00, 1'b0);
        push(1'b1, 32'h12345680, 1'b0);
        ack_cyc.delete();
        for (int k = 0; k < 20 && ack_cyc.size() < 4; k++) begin
            @(posedge clk);
            #2;
        end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("contention_acks", 32'(ack_cyc.size()), 32'd4);
        for (int i = 1; i < ack_cyc.size(); i++)
            chk("contention_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        repeat (5) @(posedge clk);
        #2;
        chk("contention_sb_empty", 32'(sbq.size()), 32'd0);

        // request withdrawn during ACCESS still completes, exactly once
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        push(1'b0, 32'hDEADBEEF, 1'b0);
        ack_cyc.delete();
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (8) @(posedge clk);
        #2;
        chk("early_drop_acks", 32'(ack_cyc.size()), 32'd1);
        chk("early_drop_sb_empty", 32'(sbq.size()), 32'd0);

        // reset during ACCESS of an m1 write
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h40, 32'h55AA55AA);
        ack_cyc.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_dm_we_before", 32'(bus.dm_we), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_mid_dm_we_async", 32'(bus.dm_we), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        RESET = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mid_no_ack", 32'(ack_cyc.size()), 32'd0);
        chk("rst_mid_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        push(1'b0, 32'h12345680, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (5) @(posedge clk);
        #2;
        chk("post_rst_tie_acks", 32'(ack_cyc.size()), 32'd1);
        chk("post_rst_sb_empty", 32'(sbq.size()), 32'd0);

        // fixed priority: m0 re-requesting continuously starves m1
        f_ack0 = 0;
        f_ack1 = 0;
        @(negedge clk);
        bus1.m0_req = 1'b1;
        bus1.m1_req = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        bus1.m0_req = 1'b0;
        bus1.m1_req = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("fixed_m1_acks", 32'(f_ack1), 32'd0);
        chk("fixed_m0_acks_ge6", 32'(f_ack0 >= 6), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
